sha_batch_scheduler: RTL



---
 rtl/miner_pkg.sv | 18 +
 rtl/hash_scan_unit.sv | 53 +++++
 rtl/sha_batch_scheduler.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/miner_pkg.sv
// Shared types and defaults for the mining datapath.
//   sched_state_t : batch scheduler FSM states
//   HASH_W        : default hash / target width
//   NONCE_W       : default nonce width
package miner_pkg;

  localparam int HASH_W  = 256;
  localparam int NONCE_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    SCAN,
    FINISH
  } sched_state_t;

endpackage

// File: rtl/hash_scan_unit.sv
// Serial hash scanner: walks the per-core hashes one index per cycle and
// compares each against the target.
// Ports:
//   clk, n_rst  : clock, async active-low reset
//   scan_en     : high while scanning; low parks the index at 0
//   active      : number of cores in the current batch
//   core_hash   : packed hashes, core i at [i*HASH_W +: HASH_W]
//   target      : hit threshold (hit when hash < target, unsigned)
//   idx         : core index being compared this cycle
//   hit         : selected hash is below target
//   last        : idx is the final active core of the batch
module hash_scan_unit #(
  parameter int NUM_CORES  = 10,
  parameter int CORE_IDX_W = 4,
  parameter int HASH_W     = miner_pkg::HASH_W
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        scan_en,
  input  logic [CORE_IDX_W:0]         active,
  input  logic [NUM_CORES*HASH_W-1:0] core_hash,
  input  logic [HASH_W-1:0]           target,
  output logic [CORE_IDX_W-1:0]       idx,
  output logic                        hit,
  output logic                        last
);

  logic [CORE_IDX_W-1:0] idx_q, idx_d;
  logic [HASH_W-1:0]     sel_hash;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) idx_q <= '0;
    else        idx_q <= idx_d;
  end

  // Index only advances while scanning so every scan starts from core 0.
  always_comb begin
    idx_d = scan_en ? idx_q + CORE_IDX_W'(1) : '0;
  end

  // Out-of-range indices select all-ones, which can never be a hit.
  always_comb begin
    sel_hash = '1;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (idx_q == CORE_IDX_W'(i)) sel_hash = core_hash[i*HASH_W +: HASH_W];
    end
  end

  assign idx  = idx_q;
  assign hit  = sel_hash < target;
  assign last = {1'b0, idx_q} == (active - (CORE_IDX_W+1)'(1));

endmodule

// File: rtl/sha_batch_scheduler.sv
// Batch scheduler for the replicated SHA cores. Launches up to NUM_CORES
// cores one per cycle, waits for all of them, scans their hashes against
// the target and then reports a hit, moves to the next batch, or declares
// the nonce space exhausted.
// Ports:
//   clk, n_rst   : clock, async active-low reset
//   start, abort : job control pulses (abort wins)
//   target       : hit threshold
//   core_done    : per-core completion pulses
//   core_hash    : packed per-core hashes
//   core_start   : per-core start pulses
//   nonce_base   : core i hashes nonce_base + i
//   busy, done, found, found_nonce, error : job status (done/found/error sticky)
module sha_batch_scheduler #(
  parameter int NUM_CORES    = 10,
  parameter int CORE_IDX_W   = 4,
  parameter int NONCE_W      = miner_pkg::NONCE_W,
  parameter int HASH_W       = miner_pkg::HASH_W,
  parameter int WAIT_TIMEOUT = 4096
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [HASH_W-1:0]           target,
  input  logic [NUM_CORES-1:0]        core_done,
  input  logic [NUM_CORES*HASH_W-1:0] core_hash,
  output logic [NUM_CORES-1:0]        core_start,
  output logic [NONCE_W-1:0]          nonce_base,
  output logic                        busy,
  output logic                        done,
  output logic                        found,
  output logic [NONCE_W-1:0]          found_nonce,
  output logic                        error
);

  import miner_pkg::*;

  localparam int CNT_W = CORE_IDX_W + 1;
  localparam int TMO_W = $clog2(WAIT_TIMEOUT + 1);

  sched_state_t          state_q, state_d;
  logic [CORE_IDX_W-1:0] launch_cnt_q, launch_cnt_d;
  logic [NUM_CORES-1:0]  launched_q, launched_d;
  logic [NUM_CORES-1:0]  done_mask_q, done_mask_d;
  logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic [NONCE_W-1:0]    nonce_base_q, nonce_base_d;
  logic [NONCE_W-1:0]    found_nonce_q, found_nonce_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic                  found_q, found_d, error_q, error_d;

  logic [NONCE_W:0]      remaining;
  logic                  exhausted;
  logic [CNT_W-1:0]      active;
  logic [NUM_CORES-1:0]  active_mask;
  logic                  launch_last;
  logic [CORE_IDX_W-1:0] scan_idx;
  logic                  scan_hit, scan_last;

  // Nonces left from the current base, computed one bit wider so a base of
  // 0 yields the full 2**NONCE_W. Active follows nonce_base, so it is
  // already correct in the first LAUNCH cycle of every batch.
  always_comb begin
    remaining = {1'b1, {NONCE_W{1'b0}}} - {1'b0, nonce_base_q};
    exhausted = remaining <= (NONCE_W+1)'(NUM_CORES);
    active    = exhausted ? remaining[CNT_W-1:0] : CNT_W'(NUM_CORES);
    for (int i = 0; i < NUM_CORES; i++) active_mask[i] = CNT_W'(i) < active;
    launch_last = {1'b0, launch_cnt_q} == (active - CNT_W'(1));
  end

  always_comb begin
    core_start = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      core_start[i] = (state_q == LAUNCH) && (launch_cnt_q == CORE_IDX_W'(i));
    end
  end

  hash_scan_unit #(
    .NUM_CORES (NUM_CORES),
    .CORE_IDX_W(CORE_IDX_W),
    .HASH_W    (HASH_W)
  ) u_scan (
    .clk      (clk),
    .n_rst    (n_rst),
    .scan_en  (state_q == SCAN),
    .active   (active),
    .core_hash(core_hash),
    .target   (target),
    .idx      (scan_idx),
    .hit      (scan_hit),
    .last     (scan_last)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      launch_cnt_q  <= '0;
      launched_q    <= '0;
      done_mask_q   <= '0;
      tmo_cnt_q     <= '0;
      nonce_base_q  <= '0;
      found_nonce_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      found_q       <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      launch_cnt_q  <= launch_cnt_d;
      launched_q    <= launched_d;
      done_mask_q   <= done_mask_d;
      tmo_cnt_q     <= tmo_cnt_d;
      nonce_base_q  <= nonce_base_d;
      found_nonce_q <= found_nonce_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      found_q       <= found_d;
      error_q       <= error_d;
    end
  end

  // Completions are only accepted from cores already started in this
  // batch, which filters idle/unlaunched spurious pulses and also lets
  // completions during LAUNCH count.
  always_comb begin
    state_d       = state_q;
    launch_cnt_d  = launch_cnt_q;
    launched_d    = launched_q | core_start;
    done_mask_d   = done_mask_q | (core_done & launched_q);
    tmo_cnt_d     = tmo_cnt_q;
    nonce_base_d  = nonce_base_q;
    found_nonce_d = found_nonce_q;
    busy_d        = busy_q;
    done_d        = done_q;
    found_d       = found_q;
    error_d       = error_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d        = 1'b1;
          done_d        = 1'b0;
          found_d       = 1'b0;
          found_nonce_d = '0;
          error_d       = 1'b0;
          nonce_base_d  = '0;
          launch_cnt_d  = '0;
          launched_d    = '0;
          done_mask_d   = '0;
          state_d       = LAUNCH;
        end
      end
      LAUNCH: begin
        if (launch_last) begin
          tmo_cnt_d = '0;
          state_d   = WAIT;
        end else begin
          launch_cnt_d = launch_cnt_q + CORE_IDX_W'(1);
        end
      end
      WAIT: begin
        if (done_mask_d == active_mask) begin
          tmo_cnt_d = '0;
          state_d   = SCAN;
        end else if (tmo_cnt_q == TMO_W'(WAIT_TIMEOUT - 1)) begin
          error_d = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = FINISH;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      SCAN: begin
        if (scan_hit) begin
          found_nonce_d = nonce_base_q + NONCE_W'(scan_idx);
          found_d       = 1'b1;
          done_d        = 1'b1;
          busy_d        = 1'b0;
          state_d       = FINISH;
        end else if (scan_last) begin
          if (exhausted) begin
            done_d  = 1'b1;
            found_d = 1'b0;
            busy_d  = 1'b0;
            state_d = FINISH;
          end else begin
            nonce_base_d = nonce_base_q + NONCE_W'(NUM_CORES);
            launch_cnt_d = '0;
            launched_d   = '0;
            done_mask_d  = '0;
            state_d      = LAUNCH;
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort overrides everything decided above, including a same-cycle start.
    if (abort) begin
      state_d       = IDLE;
      launch_cnt_d  = '0;
      busy_d        = 1'b0;
      done_d        = 1'b0;
      found_d       = 1'b0;
      nonce_base_d  = nonce_base_q;
      found_nonce_d = found_nonce_q;
      error_d       = error_q;
    end
  end

  assign nonce_base  = nonce_base_q;
  assign found_nonce = found_nonce_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign found       = found_q;
  assign error       = error_q;

endmodule
